axi_config_regfile: RTL and testbench
=====================================

AXI_CONFIG_REGFILE -- requirements
Module: axi_config_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of raddr/waddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register width; only 32 is supported, other values are an elaboration error.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: byte-strobe width.
REQ-004 SHALL have parameter BASE_ADDR, default 0: byte address of register 0, aligned to 64 bytes.
REQ-005 SHALL have parameter ID_VALUE, default 32'hC0F1_0001: constant returned by the ID register.
REQ-006 SHALL have parameter NUM_GP, range 1..8, default 4: number of general-purpose registers.
REQ-007 SHALL have ports, in order:
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  reset.
- raddr  in  ADDR_WIDTH  read byte address.
- rd  in  1  read strobe, one request per high cycle.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  read data valid.
- wr  in  1  write strobe, one write per high cycle.
- waddr  in  ADDR_WIDTH  write byte address.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  byte enables.
- status_in  in  32  live status.
- irq_in  in  32  interrupt event bits, level-sampled each cycle.
- ctrl_out  out  32  CTRL register.
- pulse_out  out  32  single-cycle pulses.
- gp_out  out  NUM_GP*32  GP registers; GP[i] occupies bits [32i+31:32i].
- irq_out  out  1  interrupt.
REQ-008 SHALL use one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).

Function
REQ-009 SHALL decode offset = addr - BASE_ADDR and word index = offset[5:2]. addr[1:0] SHALL be ignored. Addresses with offset outside 0..0x3F SHALL be unmapped.
REQ-010 Register map by word index:
- 0 ID: RO, returns ID_VALUE.
- 1 SCRATCH: RW.
- 2 CTRL: RW, drives ctrl_out.
- 3 PULSE: W1P, reads return 0.
- 4 STATUS: RO, status_in registered once.
- 5 IRQ_STAT: sticky, W1C.
- 6 IRQ_EN: RW.
- 7 WR_CNT: RO.
- 8..8+NUM_GP-1: GP, RW.
- All other indices: unmapped.
REQ-011 RW write SHALL update only byte lanes with wstrb set; an all-zero wstrb SHALL change nothing and SHALL still count as a write.
REQ-012 W1C and W1P writes SHALL act only on bits within strobed bytes.
REQ-013 A PULSE write SHALL drive pulse_out = wdata & strobe mask for exactly the next cycle, then 0. Back-to-back writes SHALL produce back-to-back pulses.
REQ-014 IRQ_STAT bit n SHALL set on the cycle after irq_in[n]=1. It SHALL clear on a W1C write of 1. If set and clear occur in the same cycle, set SHALL win.
REQ-015 irq_out SHALL be registered: irq_out = |(IRQ_STAT & IRQ_EN), one cycle after either register changes.
REQ-016 WR_CNT SHALL increment by 1 for every wr cycle whose address is in the 0..0x3F window, mapped or not. It SHALL wrap 0xFFFF_FFFF -> 0.
REQ-017 Every cycle with rd=1 SHALL produce rvalid=1 exactly one cycle later, carrying that read's data. Back-to-back reads SHALL give back-to-back rvalid. rvalid SHALL be 0 otherwise.
REQ-018 Unmapped reads SHALL return 0 with rvalid. Unmapped writes SHALL be ignored except as counted by WR_CNT.
REQ-019 rdata SHALL hold its last value while rvalid=0.
REQ-020 When rd and wr target the same register in the same cycle, the read SHALL return the pre-write value.
REQ-021 Writes to RO registers SHALL have no effect.

Reset
REQ-022 While rst_n=0 at a clock edge, the following SHALL take effect on that edge:
- rvalid=0, rdata=0, pulse_out=0, irq_out=0.
- CTRL, SCRATCH, IRQ_STAT, IRQ_EN, WR_CNT, all GP and STATUS register = 0.
REQ-023 A read issued in the cycle reset asserts SHALL produce no rvalid. Reset SHALL cancel any pending pulse.
REQ-024 The first rd/wr accepted SHALL be the one in the first cycle with rst_n=1.

Verification
REQ-025 After reset, read 0x00 -> rvalid next cycle, rdata=0xC0F10001. Read 0x08 -> 0. Read 0x1C -> 0.
REQ-026 Write CTRL=0xAABBCCDD with wstrb=4'b0101 over 0x11223344 -> ctrl_out=0x11BB33DD, and readback matches.
REQ-027 Assert irq_in[3] for one cycle with IRQ_EN=0x8:
- IRQ_STAT=0x8 and irq_out=1 afterwards.
- W1C 0x8 coincident with a new irq_in[3] pulse -> bit stays 1.
- A later W1C 0x8 -> IRQ_STAT=0 and irq_out=0 one cycle later.
REQ-028 Write PULSE=0x5 on two consecutive cycles -> pulse_out=0x5 for exactly two cycles, then 0. Read PULSE -> 0.
REQ-029 Same-cycle rd and wr to SCRATCH (old value 1, new value 2) -> rdata=1. A following read -> 2.
REQ-030 Issue 3 back-to-back reads of 0x00, 0x40, 0x20:
- rvalid high for 3 consecutive cycles with data ID, 0, GP0.
- Assert rst_n=0 during the second read -> no rvalid follows it, all outputs reset.

Source files
------------

// File: rtl/axi_config_regfile.sv
// Configuration register file: 64-byte window of 32-bit registers with ID,
// scratch, control, pulse, status, sticky interrupt, write-counter and
// general-purpose registers. Reads return data one cycle after rd.
module axi_config_regfile #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    STRB_WIDTH = DATA_WIDTH/8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [31:0]           ID_VALUE   = 32'hC0F1_0001,
   parameter int                    NUM_GP     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  raddr,
   input  logic                   rd,
   output logic [DATA_WIDTH-1:0]  rdata,
   output logic                   rvalid,
   input  logic                   wr,
   input  logic [ADDR_WIDTH-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0]  wdata,
   input  logic [STRB_WIDTH-1:0]  wstrb,
   input  logic [31:0]            status_in,
   input  logic [31:0]            irq_in,
   output logic [31:0]            ctrl_out,
   output logic [31:0]            pulse_out,
   output logic [NUM_GP*32-1:0]   gp_out,
   output logic                   irq_out
);

   // Elaboration-time parameter sanity checks.
   if (DATA_WIDTH != 32 || STRB_WIDTH != 4) begin : g_bad_width
      $error("axi_config_regfile: only DATA_WIDTH=32 / STRB_WIDTH=4 supported");
   end
   if (NUM_GP < 1 || NUM_GP > 8) begin : g_bad_num_gp
      $error("axi_config_regfile: NUM_GP must be in 1..8");
   end
   if (BASE_ADDR[5:0] != 6'd0) begin : g_bad_base
      $error("axi_config_regfile: BASE_ADDR must be 64-byte aligned");
   end

   localparam logic [3:0] IDX_ID       = 4'd0;
   localparam logic [3:0] IDX_SCRATCH  = 4'd1;
   localparam logic [3:0] IDX_CTRL     = 4'd2;
   localparam logic [3:0] IDX_PULSE    = 4'd3;
   localparam logic [3:0] IDX_STATUS   = 4'd4;
   localparam logic [3:0] IDX_IRQ_STAT = 4'd5;
   localparam logic [3:0] IDX_IRQ_EN   = 4'd6;
   localparam logic [3:0] IDX_WR_CNT   = 4'd7;
   localparam logic [3:0] IDX_GP0      = 4'd8;

   logic [31:0] scratch_q, ctrl_q, status_q, irq_stat_q, irq_en_q, wr_cnt_q;
   logic [31:0] gp_q [NUM_GP];

   // Address decode: offset from base, window check, word index.
   logic [ADDR_WIDTH-1:0] roff, woff;
   logic                  r_in_win, w_in_win;
   logic [3:0]            r_idx, w_idx;

   assign roff     = raddr - BASE_ADDR;
   assign woff     = waddr - BASE_ADDR;
   assign r_in_win = (roff[ADDR_WIDTH-1:6] == '0);
   assign w_in_win = (woff[ADDR_WIDTH-1:6] == '0);
   assign r_idx    = roff[5:2];
   assign w_idx    = woff[5:2];

   // Byte-lane offset bits are intentionally ignored.
   logic unused_lane_bits;
   assign unused_lane_bits = ^{roff[1:0], woff[1:0]};

   logic        w_hit;
   logic [31:0] wmask, wbits;
   assign w_hit = wr && w_in_win;
   assign wbits = wdata & wmask;

   // Expand byte strobes into a bit mask.
   always_comb begin
      // NOTE: default assignment first so no path leaves wmask unassigned (no latch).
      wmask = '0;
      for (int b = 0; b < 4; b++) begin
         wmask[8*b +: 8] = {8{wstrb[b]}};
      end
   end

   logic we_scratch, we_ctrl, we_pulse, we_irq_stat, we_irq_en;
   assign we_scratch  = w_hit && (w_idx == IDX_SCRATCH);
   assign we_ctrl     = w_hit && (w_idx == IDX_CTRL);
   assign we_pulse    = w_hit && (w_idx == IDX_PULSE);
   assign we_irq_stat = w_hit && (w_idx == IDX_IRQ_STAT);
   assign we_irq_en   = w_hit && (w_idx == IDX_IRQ_EN);

   // Scratch, control, interrupt enable, status sample and write counter.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state so every register
      // sees pre-edge values regardless of statement order.
      if (!rst_n) begin
         scratch_q <= '0;
         ctrl_q    <= '0;
         irq_en_q  <= '0;
         status_q  <= '0;
         wr_cnt_q  <= '0;
      end else begin
         status_q <= status_in;
         if (we_scratch) scratch_q <= (scratch_q & ~wmask) | wbits;
         if (we_ctrl)    ctrl_q    <= (ctrl_q    & ~wmask) | wbits;
         if (we_irq_en)  irq_en_q  <= (irq_en_q  & ~wmask) | wbits;
         if (w_hit)      wr_cnt_q  <= wr_cnt_q + 32'd1;
      end
   end

   // General-purpose registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the GP array is a small register bank with a required
         // reset value, so every entry is cleared explicitly here.
         for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_GP; i++) begin
            if (w_hit && (w_idx == 4'(IDX_GP0 + 4'(i))))
               gp_q[i] <= (gp_q[i] & ~wmask) | wbits;
         end
      end
   end

   // Sticky interrupt status (set wins over W1C) and registered irq output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_stat_q <= '0;
         irq_out    <= 1'b0;
      end else begin
         irq_stat_q <= (irq_stat_q & ~(we_irq_stat ? wbits : 32'd0)) | irq_in;
         irq_out    <= |(irq_stat_q & irq_en_q);
      end
   end

   // One-cycle pulses from PULSE writes.
   always_ff @(posedge clk) begin
      if (!rst_n) pulse_out <= '0;
      else        pulse_out <= we_pulse ? wbits : 32'd0;
   end

   // Read mux over pre-write register values.
   logic [31:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      if (r_in_win) begin
         case (r_idx)
            IDX_ID:       rd_mux = ID_VALUE;
            IDX_SCRATCH:  rd_mux = scratch_q;
            IDX_CTRL:     rd_mux = ctrl_q;
            IDX_PULSE:    rd_mux = '0;
            IDX_STATUS:   rd_mux = status_q;
            IDX_IRQ_STAT: rd_mux = irq_stat_q;
            IDX_IRQ_EN:   rd_mux = irq_en_q;
            IDX_WR_CNT:   rd_mux = wr_cnt_q;
            default: begin
               for (int i = 0; i < NUM_GP; i++) begin
                  if (r_idx == 4'(IDX_GP0 + 4'(i))) rd_mux = gp_q[i];
               end
            end
         endcase
      end
   end

   // Read response: valid one cycle after rd, data held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= rd;
         if (rd) rdata <= rd_mux;
      end
   end

   assign ctrl_out = ctrl_q;

   for (genvar g = 0; g < NUM_GP; g++) begin : g_gp_out
      assign gp_out[32*g +: 32] = gp_q[g];
   end

endmodule

// File: tb/tb_axi_config_regfile.sv
// Directed testbench for axi_config_regfile: inputs driven on the falling
// edge, outputs sampled on the following falling edge.
module tb_axi_config_regfile;

   localparam logic [31:0] ID = 32'hC0F1_0001;

   logic         clk;
   logic         rst_n;
   logic [31:0]  raddr;
   logic         rd;
   logic [31:0]  rdata;
   logic         rvalid;
   logic         wr;
   logic [31:0]  waddr;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic [31:0]  status_in;
   logic [31:0]  irq_in;
   logic [31:0]  ctrl_out;
   logic [31:0]  pulse_out;
   logic [127:0] gp_out;
   logic         irq_out;

   int vectors = 0;
   int miscompares = 0;

   axi_config_regfile dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr     (raddr),
      .rd        (rd),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .wr        (wr),
      .waddr     (waddr),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .status_in (status_in),
      .irq_in    (irq_in),
      .ctrl_out  (ctrl_out),
      .pulse_out (pulse_out),
      .gp_out    (gp_out),
      .irq_out   (irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      wr = 1'b1; waddr = addr; wdata = data; wstrb = strb;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      rd = 1'b1; raddr = addr;
      @(negedge clk);
      rd = 1'b0;
      check({tag, " rvalid"}, 128'(rvalid), 128'(1'b1));
      check({tag, " rdata"}, 128'(rdata), 128'(exp));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rvalid"}, 128'(rvalid), 128'd0);
      check({tag, " rdata"}, 128'(rdata), 128'd0);
      check({tag, " ctrl_out"}, 128'(ctrl_out), 128'd0);
      check({tag, " pulse_out"}, 128'(pulse_out), 128'd0);
      check({tag, " irq_out"}, 128'(irq_out), 128'd0);
      check({tag, " gp_out"}, gp_out, 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rd = 1'b0; raddr = '0; wr = 1'b0; waddr = '0;
      wdata = '0; wstrb = '0; status_in = '0; irq_in = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // First cycle out of reset carries a read.
      rst_n = 1'b1; rd = 1'b1; raddr = 32'h00;
      @(negedge clk);
      rd = 1'b0;
      check("first read rvalid", 128'(rvalid), 128'd1);
      check("first read id", 128'(rdata), 128'(ID));
      @(negedge clk);
      check("idle rvalid", 128'(rvalid), 128'd0);
      check("idle rdata hold", 128'(rdata), 128'(ID));
      do_read(32'h08, 32'h0, "ctrl reset");
      do_read(32'h1C, 32'h0, "wr_cnt reset");

      // Byte-strobed CTRL write.
      do_write(32'h08, 32'h1122_3344, 4'hF);
      do_write(32'h08, 32'hAABB_CCDD, 4'b0101);
      check("ctrl_out strobed", 128'(ctrl_out), 128'(32'h11BB_33DD));
      do_read(32'h08, 32'h11BB_33DD, "ctrl readback");

      // Zero-strobe write changes nothing but counts.
      do_write(32'h04, 32'hFFFF_FFFF, 4'h0);
      do_read(32'h04, 32'h0, "scratch zero strb");
      do_read(32'h1C, 32'd3, "wr_cnt 3");

      // Interrupt path.
      do_write(32'h18, 32'h8, 4'hF);
      irq_in = 32'h8;
      @(negedge clk);
      irq_in = 32'h0;
      @(negedge clk);
      check("irq_out set", 128'(irq_out), 128'd1);
      do_read(32'h14, 32'h8, "irq_stat set");
      irq_in = 32'h8;
      do_write(32'h14, 32'h8, 4'hF);
      irq_in = 32'h0;
      do_read(32'h14, 32'h8, "irq set wins");
      check("irq_out still", 128'(irq_out), 128'd1);
      do_write(32'h14, 32'h8, 4'hF);
      check("irq_out lag", 128'(irq_out), 128'd1);
      @(negedge clk);
      check("irq_out clear", 128'(irq_out), 128'd0);
      do_read(32'h14, 32'h0, "irq_stat clear");

      // Back-to-back pulses.
      wr = 1'b1; waddr = 32'h0C; wdata = 32'h5; wstrb = 4'hF;
      @(negedge clk);
      check("pulse 1", 128'(pulse_out), 128'(32'h5));
      @(negedge clk);
      wr = 1'b0;
      check("pulse 2", 128'(pulse_out), 128'(32'h5));
      @(negedge clk);
      check("pulse end", 128'(pulse_out), 128'd0);
      do_read(32'h0C, 32'h0, "pulse read");

      // Same-cycle read and write of SCRATCH.
      do_write(32'h04, 32'h1, 4'hF);
      rd = 1'b1; raddr = 32'h04;
      wr = 1'b1; waddr = 32'h04; wdata = 32'h2; wstrb = 4'hF;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      check("rw collide rdata", 128'(rdata), 128'(32'h1));
      do_read(32'h04, 32'h2, "scratch new");

      // RO, unmapped and out-of-window writes.
      do_write(32'h00, 32'hFFFF_FFFF, 4'hF);
      do_read(32'h00, ID, "id ro");
      do_write(32'h3C, 32'hFFFF_FFFF, 4'hF);
      do_read(32'h3C, 32'h0, "unmapped read");
      do_write(32'h40, 32'hFFFF_FFFF, 4'hF);
      do_read(32'h1C, 32'd12, "wr_cnt 12");

      // GP registers and ignored byte-offset bits.
      do_write(32'h20, 32'hDEAD_BEEF, 4'hF);
      do_write(32'h2F, 32'h1234_5678, 4'hF);
      check("gp_out", gp_out, {32'h1234_5678, 32'h0, 32'h0, 32'hDEAD_BEEF});
      do_read(32'h22, 32'hDEAD_BEEF, "gp0 offset addr");

      // Status sampling.
      status_in = 32'hCAFE_0001;
      @(negedge clk);
      do_read(32'h10, 32'hCAFE_0001, "status");

      // Three back-to-back reads.
      rd = 1'b1; raddr = 32'h00;
      @(negedge clk);
      check("b2b 0 rvalid", 128'(rvalid), 128'd1);
      check("b2b 0 data", 128'(rdata), 128'(ID));
      raddr = 32'h40;
      @(negedge clk);
      check("b2b 1 rvalid", 128'(rvalid), 128'd1);
      check("b2b 1 data", 128'(rdata), 128'd0);
      raddr = 32'h20;
      @(negedge clk);
      rd = 1'b0;
      check("b2b 2 rvalid", 128'(rvalid), 128'd1);
      check("b2b 2 data", 128'(rdata), 128'(32'hDEAD_BEEF));
      @(negedge clk);
      check("b2b end rvalid", 128'(rvalid), 128'd0);

      // Reset during the second read, with a pulse pending.
      rd = 1'b1; raddr = 32'h00;
      wr = 1'b1; waddr = 32'h0C; wdata = 32'h3; wstrb = 4'hF;
      @(negedge clk);
      wr = 1'b0;
      check("pre-reset data", 128'(rdata), 128'(ID));
      check("pre-reset pulse", 128'(pulse_out), 128'(32'h3));
      raddr = 32'h40; rst_n = 1'b0;
      @(negedge clk);
      rd = 1'b0;
      check_reset_outputs("mid reset");
      @(negedge clk);
      check("post reset rvalid", 128'(rvalid), 128'd0);
      rst_n = 1'b1;
      do_read(32'h1C, 32'h0, "wr_cnt after reset");
      do_read(32'h04, 32'h0, "scratch after reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
